// File: rtl/ball_collision_ctrl.sv
// Per-frame ball collision controller: pulls ball steps over a req/ack handshake and
// reports wall/platform collisions, ball loss and frame completion.
module ball_collision_ctrl #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned PLAT_W    = 64,
  parameter int unsigned SIZE_W    = 4,
  parameter int unsigned MAX_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cal_frame,
  input  logic              i_game_start,
  output logic              o_ball_req,
  input  logic              i_ball_ack,
  input  logic              i_ball_frame_term,
  input  logic [9:0]        i_ballX,
  input  logic [8:0]        i_ballY,
  input  logic [SIZE_W-1:0] i_ball_size,
  input  logic [1:0]        i_ball_speedX,
  input  logic [1:0]        i_ball_speedY,
  input  logic [9:0]        i_platX,
  input  logic [8:0]        i_platY,
  output logic              o_ball_collision,
  output logic [5:0]        o_direc_var,
  output logic              o_ball_lost,
  output logic              o_frame_done,
  output logic              o_err_watchdog
);

  localparam int unsigned SUM_W   = 11;
  localparam int unsigned CNT_W   = $clog2(MAX_STEPS + 1);
  localparam int unsigned ZONE_SH = $clog2(PLAT_W / 16);
  localparam logic [5:0]  CODE_FLIP_X = 6'd18;
  localparam logic [5:0]  CODE_FLIP_Y = 6'd19;
  localparam logic [1:0]  SPD_POS = 2'b01;
  localparam logic [1:0]  SPD_NEG = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, CHECK, COLL, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_y_q, pend_y_d;
  logic               wd_d, req_d, coll_d, lost_d, done_d;
  logic [5:0]         direc_d;

  logic [9:0]         bx_q, px_q;
  logic [8:0]         by_q, py_q;
  logic [SIZE_W-1:0]  bs_q;
  logic [1:0]         bvx_q, bvy_q;
  logic               hs;

  assign hs = o_ball_req & i_ball_ack;

  // Ball and platform snapshot taken on each accepted step
  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q  <= '0;
      by_q  <= '0;
      bs_q  <= '0;
      bvx_q <= '0;
      bvy_q <= '0;
      px_q  <= '0;
      py_q  <= '0;
    end else if (hs) begin
      bx_q  <= i_ballX;
      by_q  <= i_ballY;
      bs_q  <= i_ball_size;
      bvx_q <= i_ball_speedX;
      bvy_q <= i_ball_speedY;
      px_q  <= i_platX;
      py_q  <= i_platY;
    end
  end

  logic [SUM_W-1:0] x_w, y_w, s_w, px_w, py_w, ctr_w, diff_w, off_w;
  logic             floor_hit, plat_hit, side_hit, top_hit;
  logic [5:0]       zone_code;

  assign x_w  = SUM_W'(bx_q);
  assign y_w  = SUM_W'(by_q);
  assign s_w  = SUM_W'(bs_q);
  assign px_w = SUM_W'(px_q);
  assign py_w = SUM_W'(py_q);

  // Geometry checks on the latched step
  always_comb begin
    floor_hit = (bvy_q == SPD_POS) && (y_w + s_w >= SUM_W'(SCREEN_H - 1));
    plat_hit  = (bvy_q == SPD_POS) && (y_w + s_w + SUM_W'(1) == py_w) &&
                (x_w + s_w >= px_w) && (x_w <= px_w + SUM_W'(PLAT_W - 1));
    side_hit  = ((bvx_q == SPD_NEG) && (x_w == '0)) ||
                ((bvx_q == SPD_POS) && (x_w + s_w == SUM_W'(SCREEN_W - 1)));
    top_hit   = (bvy_q == SPD_NEG) && (y_w == '0);
    ctr_w     = x_w + (s_w >> 1);
    diff_w    = ctr_w - px_w;
    if (ctr_w < px_w) begin
      off_w = '0;
    end else if (diff_w > SUM_W'(PLAT_W - 1)) begin
      off_w = SUM_W'(PLAT_W - 1);
    end else begin
      off_w = diff_w;
    end
    zone_code = 6'(off_w >> ZONE_SH) + 6'd1;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_y_d = 1'b0;
    wd_d     = o_err_watchdog;
    coll_d   = 1'b0;
    direc_d  = '0;
    lost_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cal_frame) begin
          state_d = REQ;
          cnt_d   = '0;
          wd_d    = 1'b0;
        end
      end
      REQ: begin
        if (i_ball_frame_term) begin
          state_d = DONE;
        end else if (hs) begin
          if (cnt_q == CNT_W'(MAX_STEPS)) begin
            wd_d    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (floor_hit) begin
          lost_d  = 1'b1;
          state_d = DONE;
        end else if (plat_hit) begin
          coll_d  = 1'b1;
          direc_d = zone_code;
          state_d = COLL;
        end else if (side_hit) begin
          coll_d   = 1'b1;
          direc_d  = CODE_FLIP_X;
          pend_y_d = top_hit;
          state_d  = COLL;
        end else if (top_hit) begin
          coll_d  = 1'b1;
          direc_d = CODE_FLIP_Y;
          state_d = COLL;
        end else begin
          state_d = REQ;
        end
      end
      COLL: begin
        // Corner hit: second pulse carries the Y flip on the following cycle
        if (pend_y_q) begin
          coll_d  = 1'b1;
          direc_d = CODE_FLIP_Y;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == REQ);

    if (i_game_start) begin
      state_d  = IDLE;
      pend_y_d = 1'b0;
      req_d    = 1'b0;
      coll_d   = 1'b0;
      direc_d  = '0;
      lost_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      pend_y_q         <= 1'b0;
      o_ball_req       <= 1'b0;
      o_ball_collision <= 1'b0;
      o_direc_var      <= '0;
      o_ball_lost      <= 1'b0;
      o_frame_done     <= 1'b0;
      o_err_watchdog   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pend_y_q         <= pend_y_d;
      o_ball_req       <= req_d;
      o_ball_collision <= coll_d;
      o_direc_var      <= direc_d;
      o_ball_lost      <= lost_d;
      o_frame_done     <= done_d;
      o_err_watchdog   <= wd_d;
    end
  end

endmodule
